// File: rtl/key_filter_debounced.sv
`default_nettype none
// ============================================================================
// key_filter_debounced: synchronise + debounce NUM_KEYS buttons, accept only
// single-key presses. Optional auto-repeat under `define KEY_FILTER_REPEAT_EN.
// Revision: 1.0
// ============================================================================
module key_filter_debounced #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_CYCLES   = 25000000,
    localparam int IDX_W          = $clog2(NUM_KEYS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] filtered_key,
    output logic [IDX_W-1:0]    key_index,
    output logic                key_valid,
    output logic                key_press,
    output logic                key_reject
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (NUM_KEYS < 2 || NUM_KEYS > 16 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("key_filter_debounced: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] deb_q, deb_d;

    // Internally 1 always means pressed.
    assign key_in = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             differ, at_last;

        assign differ    = sync2_q[gi] ^ deb_q[gi];
        assign at_last   = (cnt_q == DB_LAST);
        assign cnt_d     = (differ && !at_last) ? cnt_q + 1'b1 : '0;
        assign deb_d[gi] = (differ && at_last) ? sync2_q[gi] : deb_q[gi];

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    state_t              state_q, state_d;
    logic [NUM_KEYS-1:0] latch_q, latch_d;
    logic [NUM_KEYS-1:0] filt_q, filt_d;
    logic [IDX_W-1:0]    idx_q, idx_d, enc;
    logic                valid_q, valid_d;
    logic                press_q, press_d;
    logic                rej_q, rej_d;
    logic                deb_none, deb_one;

    assign deb_none = (deb_q == '0);
    assign deb_one  = !deb_none && ((deb_q & (deb_q - 1'b1)) == '0);

    always_comb begin
        enc = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (deb_q[i]) begin
                enc = IDX_W'(i);
            end
        end
    end

`ifdef KEY_FILTER_REPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_q, rpt_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        filt_d  = '0;
        idx_d   = '0;
        press_d = 1'b0;
        rej_d   = 1'b0;
`ifdef KEY_FILTER_REPEAT_EN
        rpt_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (deb_one) begin
                    state_d = S_PRESSED;
                    latch_d = deb_q;
                    filt_d  = deb_q;
                    idx_d   = enc;
                    press_d = 1'b1;
                end else if (!deb_none) begin
                    state_d = S_LOCKOUT;
                    rej_d   = 1'b1;
                end
            end
            S_PRESSED: begin
                if (deb_q == latch_q) begin
                    filt_d = latch_q;
                    idx_d  = idx_q;
`ifdef KEY_FILTER_REPEAT_EN
                    if (rpt_q == RPT_LAST) begin
                        press_d = 1'b1;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
`endif
                end else if (deb_none) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOCKOUT;
                    rej_d   = 1'b1;
                end
            end
            S_LOCKOUT: begin
                // Held keys must all be released before anything is accepted again.
                if (deb_none) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        valid_d = |filt_d;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            latch_q <= '0;
            filt_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            press_q <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            filt_q  <= filt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            press_q <= press_d;
            rej_q   <= rej_d;
        end
    end

    assign filtered_key = filt_q;
    assign key_index    = idx_q;
    assign key_valid    = valid_q;
    assign key_press    = press_q;
    assign key_reject   = rej_q;

endmodule
`default_nettype wire

// File: doc/key_filter_debounced.md
# key_filter_debounced

Parametrised, clocked successor to the combinational single-keypress filter. It synchronises and debounces NUM_KEYS raw push-buttons, then accepts a press only when exactly one debounced key is down. It emits a one-hot level, a binary index and a single-cycle press strobe. It sits between the board KEY pins and the game-control FSM and blocks multi-key presses for the whole time any key stays held.

## Interface
- NUM_KEYS, 4, number of key channels (2..16)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to change a debounced key state (≥1)
- ACTIVE_LOW, 1, 1: a raw key reads 0 when pressed (DE1-SoC); 0: a raw key reads 1 when pressed
- REPEAT_CYCLES, 25000000, auto-repeat period (used only with KEY_FILTER_REPEAT_EN)
- IDX_W, $clog2(NUM_KEYS), width of key_index (localparam)

- clock  in  1  system clock; every register is clocked on its rising edge
- reset_n  in  1  synchronous, active-low reset
- key_raw  in  NUM_KEYS  asynchronous raw key pins
- filtered_key  out  NUM_KEYS  one-hot level of the accepted key; 0 otherwise
- key_index  out  IDX_W  binary index of the accepted key; 0 when none is accepted
- key_valid  out  1  high while a key is accepted (equals |filtered_key)
- key_press  out  1  one-cycle strobe when a key is accepted (and on each repeat)
- key_reject  out  1  one-cycle strobe on entry to LOCKOUT

## Operation
- Reset (reset_n low at a rising edge): synchronisers, debounced states and counters clear to "not pressed"; FSM enters IDLE; every output is 0.
- Polarity: raw inputs are inverted when ACTIVE_LOW=1, so internally 1 always means pressed.
- Synchroniser: two flops per channel.
- Debounce, per channel:
  - The counter increments while the synchronised value ≠ the debounced state.
  - The counter clears to 0 on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced state flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); the counter never wraps.
- FSM, evaluated on the debounced vector D:
  - IDLE: D = 0 → stay. D one-hot → PRESSED, latch the key, key_press=1. D has ≥2 bits set → LOCKOUT, key_reject=1.
  - PRESSED: D equals the latched key → stay. D = 0 → IDLE. Any other value (a second key, or a swap to another key) → LOCKOUT, key_reject=1.
  - LOCKOUT: outputs cleared; leave to IDLE only when D = 0. A key left held does not re-trigger.
- All outputs are registered.
  - filtered_key, key_index and key_valid reflect the current state: latched key in PRESSED, 0 otherwise.
  - Strobes are high for exactly one cycle per transition.
- Two keys that debounce in the same cycle from IDLE go straight to LOCKOUT; key_press is never asserted.

## Timing
- Press latency: a raw edge that stays stable from rising edge k is seen in D at edge k+1+DEBOUNCE_CYCLES. key_press and filtered_key assert at edge k+2+DEBOUNCE_CYCLES.
- Release latency is identical; outputs drop to 0 on that same edge.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no output change.
- reset_n low mid-press: outputs are 0 on the following edge. After release of reset, a key still held is accepted after the full press latency.
- Throughput: at most one key_press per press-release cycle, except auto-repeat.

## Configuration
- KEY_FILTER_REPEAT_EN defined:
  - In PRESSED, a repeat counter counts clock cycles from the first key_press.
  - key_press re-strobes every REPEAT_CYCLES cycles while the same key is held.
  - The counter clears on leaving PRESSED and on reset.
- Undefined: no repeat counter is synthesised; key_press fires once per acceptance and REPEAT_CYCLES is ignored.

## Test plan
All scenarios use NUM_KEYS=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
- Reset: hold reset_n=0 with key_raw=4'b1110 → all outputs 0. Release reset, hold key 0 → filtered_key=4'b0001, key_index=0, and key_press pulses once 6 cycles after reset_n rises.
- Clean press: key_raw 4'b1111→4'b1011 at edge k → key_press at edge k+6 only; filtered_key=4'b0100, key_index=2. Release → outputs 0 at k'+6.
- Bounce: toggle key 1 every 2 cycles for 20 cycles, then return high → no output change and no strobe.
- Second key while held: hold key 0, then press key 3 → key_reject pulses once, filtered_key=0. Release key 3 only → stays 0. Release all, then press key 3 → accepted normally.
- Simultaneous: key_raw→4'b1100 in one cycle → key_reject once, key_press never asserted.
- Auto-repeat (macro defined, REPEAT_CYCLES=10): hold key 2 for 35 cycles after acceptance → key_press at t, t+10, t+20, t+30. Without the macro: exactly one pulse.
